// File: rtl/axis_pkg.sv
// Shared defaults for the AXI4-Stream FIFO and the helper that sizes one stored entry.
package axis_pkg;

    localparam int DEFAULT_TDATA_BYTES = 4;
    localparam int DEFAULT_TID_BITS    = 1;
    localparam int DEFAULT_TDEST_BITS  = 1;
    localparam int DEFAULT_TUSER_BITS  = 1;
    localparam int DEFAULT_DEPTH       = 16;

    // tdata (8 bits per byte) + tstrb + tkeep (1 bit per byte each) + tlast + sideband.
    function automatic int entry_width(input int tdata_bytes, input int tid_bits,
                                       input int tdest_bits, input int tuser_bits);
        return 10 * tdata_bytes + 1 + tid_bits + tdest_bits + tuser_bits;
    endfunction

endpackage

// File: rtl/axis_if.sv
// AXI4-Stream bundle; the source drives everything except tready.
interface axis_if import axis_pkg::*; #(
    parameter int TDATA_BYTES = DEFAULT_TDATA_BYTES,
    parameter int TID_BITS    = DEFAULT_TID_BITS,
    parameter int TDEST_BITS  = DEFAULT_TDEST_BITS,
    parameter int TUSER_BITS  = DEFAULT_TUSER_BITS
) ();

    logic                     tvalid;
    logic                     tready;
    logic [8*TDATA_BYTES-1:0] tdata;
    logic [TDATA_BYTES-1:0]   tstrb;
    logic [TDATA_BYTES-1:0]   tkeep;
    logic                     tlast;
    logic [TID_BITS-1:0]      tid;
    logic [TDEST_BITS-1:0]    tdest;
    logic [TUSER_BITS-1:0]    tuser;

    modport master (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, input tready);
    modport slave  (input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, output tready);

endinterface

// File: rtl/axis_fifo_mem.sv
// Simple dual-port storage for the stream FIFO: synchronous write, asynchronous read.
module axis_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset on purpose; the pointers alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_fifo.sv
// Synchronous AXI4-Stream FIFO with optional store-and-forward release.
// Pointers carry one extra wrap bit so full, empty and occupancy fall out directly.
module axis_fifo import axis_pkg::*; #(
    parameter int TDATA_BYTES = DEFAULT_TDATA_BYTES,
    parameter int TID_BITS    = DEFAULT_TID_BITS,
    parameter int TDEST_BITS  = DEFAULT_TDEST_BITS,
    parameter int TUSER_BITS  = DEFAULT_TUSER_BITS,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter bit PACKET_MODE = 1'b0
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    axis_if.slave                  s_axis,
    axis_if.master                 m_axis,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [$clog2(DEPTH):0] pkt_count
);

    localparam int AW       = $clog2(DEPTH);
    localparam int DW       = 8 * TDATA_BYTES;
    localparam int EW       = entry_width(TDATA_BYTES, TID_BITS, TDEST_BITS, TUSER_BITS);
    localparam int LAST_IDX = DW + 2 * TDATA_BYTES;

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   pkt_q, pkt_d;
    logic          s_tready_q, s_tready_d;
    logic          release_q, release_d;
    logic          push, pop, push_last, pop_last;
    logic          full, empty, m_tvalid;
    logic [EW-1:0] wr_entry, rd_entry;

    assign wr_entry = {s_axis.tuser, s_axis.tdest, s_axis.tid, s_axis.tlast,
                       s_axis.tkeep, s_axis.tstrb, s_axis.tdata};
    assign {m_axis.tuser, m_axis.tdest, m_axis.tid, m_axis.tlast,
            m_axis.tkeep, m_axis.tstrb, m_axis.tdata} = rd_entry;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A full FIFO is released even without a stored tlast so an over-long packet
    // cannot deadlock; release_q keeps that packet draining once the first word leaves.
    assign m_tvalid = !empty && (!PACKET_MODE || (pkt_q != '0) || full || release_q);

    assign push      = s_axis.tvalid && s_tready_q;
    assign pop       = m_tvalid && m_axis.tready;
    assign push_last = push && s_axis.tlast;
    assign pop_last  = pop && rd_entry[LAST_IDX];

    always_comb begin
        // NOTE: every next-state signal gets a value before any branch, so no latch can form.
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
        pkt_d      = pkt_q + {{AW{1'b0}}, push_last} - {{AW{1'b0}}, pop_last};
        s_tready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                       (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
        release_d  = release_q;
        if (full) begin
            release_d = 1'b1;
        end
        if (pop_last || (wr_ptr_d == rd_ptr_d)) begin
            release_d = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_q      <= '0;
            s_tready_q <= 1'b0;
            release_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_q      <= pkt_d;
            s_tready_q <= s_tready_d;
            release_q  <= release_d;
        end
    end

    assign s_axis.tready = s_tready_q;
    assign m_axis.tvalid = m_tvalid;
    assign occupancy     = wr_ptr_q - rd_ptr_q;
    assign pkt_count     = pkt_q;

    axis_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk_i   (aclk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_entry)
    );

endmodule

// File: tb/tb_axis_fifo.sv
// Scoreboard bench for axis_fifo: one instance in cut-through mode, one in packet mode.
module tb_axis_fifo;

    typedef struct packed {
        logic        user;
        logic        dest;
        logic        id;
        logic        last;
        logic [3:0]  keep;
        logic [3:0]  strb;
        logic [31:0] data;
    } word_t;

    logic       aclk    = 1'b0;
    logic       aresetn = 1'b0;
    logic [4:0] occ0, pkt0, occ1, pkt1;

    axis_if s0 ();
    axis_if m0 ();
    axis_if s1 ();
    axis_if m1 ();

    axis_fifo #(.DEPTH(16), .PACKET_MODE(1'b0)) u_dut0 (
        .aclk(aclk), .aresetn(aresetn), .s_axis(s0), .m_axis(m0),
        .occupancy(occ0), .pkt_count(pkt0)
    );

    axis_fifo #(.DEPTH(16), .PACKET_MODE(1'b1)) u_dut1 (
        .aclk(aclk), .aresetn(aresetn), .s_axis(s1), .m_axis(m1),
        .occupancy(occ1), .pkt_count(pkt1)
    );

    always #5 aclk = ~aclk;

    int    checks   = 0;
    int    failures = 0;
    int    rx0      = 0;
    int    rx1      = 0;
    logic  stall0   = 1'b0;
    logic  stall1   = 1'b0;
    word_t want0[$];
    word_t want1[$];

    logic [31:0] vec [5] = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC,
                             32'hDDEE_FF00, 32'h0BAD_F00D};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic word_t mk(input logic [31:0] d, input logic l);
        word_t w;
        w      = '0;
        w.data = d;
        w.strb = 4'hF;
        w.keep = 4'hF;
        w.last = l;
        return w;
    endfunction

    function automatic word_t rand_word();
        word_t w;
        w.data = $urandom;
        w.strb = 4'($urandom_range(0, 15));
        w.keep = 4'($urandom_range(0, 15));
        w.last = 1'($urandom_range(0, 1));
        w.id   = 1'($urandom_range(0, 1));
        w.dest = 1'($urandom_range(0, 1));
        w.user = 1'($urandom_range(0, 1));
        return w;
    endfunction

    task automatic put0(input logic v, input word_t w);
        s0.tvalid = v;    s0.tdata = w.data; s0.tstrb = w.strb; s0.tkeep = w.keep;
        s0.tlast  = w.last; s0.tid = w.id;   s0.tdest = w.dest; s0.tuser = w.user;
    endtask

    task automatic put1(input logic v, input word_t w);
        s1.tvalid = v;    s1.tdata = w.data; s1.tstrb = w.strb; s1.tkeep = w.keep;
        s1.tlast  = w.last; s1.tid = w.id;   s1.tdest = w.dest; s1.tuser = w.user;
    endtask

    task automatic drain0();
        int n = 0;
        m0.tready = 1'b1;
        @(negedge aclk);
        while (occ0 != 0 && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check("drain0_occ", occ0, 0);
        m0.tready = 1'b0;
    endtask

    task automatic drain1();
        int n = 0;
        m1.tready = 1'b1;
        @(negedge aclk);
        while (occ1 != 0 && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check("drain1_occ", occ1, 0);
        m1.tready = 1'b0;
    endtask

    // Expected words enter the scoreboard when the bench's own stimulus is accepted.
    always @(negedge aclk) begin
        if (aresetn && s0.tvalid && s0.tready)
            want0.push_back({s0.tuser, s0.tdest, s0.tid, s0.tlast, s0.tkeep, s0.tstrb, s0.tdata});
        if (aresetn && s1.tvalid && s1.tready)
            want1.push_back({s1.tuser, s1.tdest, s1.tid, s1.tlast, s1.tkeep, s1.tstrb, s1.tdata});
    end

    always @(negedge aclk) begin : mon0
        word_t got;
        if (!aresetn) begin
            stall0 <= 1'b0;
        end else begin
            got = {m0.tuser, m0.tdest, m0.tid, m0.tlast, m0.tkeep, m0.tstrb, m0.tdata};
            if (stall0) check("hold_valid0", m0.tvalid, 1'b1);
            if (m0.tvalid) begin
                if (want0.size() == 0) begin
                    check("stale_word0", m0.tvalid, 1'b0);
                end else begin
                    check("payload0", got, want0[0]);
                    if (m0.tready) begin
                        void'(want0.pop_front());
                        rx0 <= rx0 + 1;
                    end
                end
            end
            stall0 <= m0.tvalid && !m0.tready;
        end
    end

    always @(negedge aclk) begin : mon1
        word_t got;
        if (!aresetn) begin
            stall1 <= 1'b0;
        end else begin
            got = {m1.tuser, m1.tdest, m1.tid, m1.tlast, m1.tkeep, m1.tstrb, m1.tdata};
            if (stall1) check("hold_valid1", m1.tvalid, 1'b1);
            if (m1.tvalid) begin
                if (want1.size() == 0) begin
                    check("stale_word1", m1.tvalid, 1'b0);
                end else begin
                    check("payload1", got, want1[0]);
                    if (m1.tready) begin
                        void'(want1.pop_front());
                        rx1 <= rx1 + 1;
                    end
                end
            end
            stall1 <= m1.tvalid && !m1.tready;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int base;
        int sent;
        bit pending;

        put0(1'b0, '0);
        put1(1'b0, '0);
        m0.tready = 1'b0;
        m1.tready = 1'b0;

        // Reset state and release timing.
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_s_tready0", s0.tready, 0);
        check("rst_m_tvalid0", m0.tvalid, 0);
        check("rst_occ0", occ0, 0);
        check("rst_pkt0", pkt0, 0);
        check("rst_s_tready1", s1.tready, 0);
        tick();
        aresetn = 1'b1;
        @(negedge aclk);
        check("rel_s_tready0_low", s0.tready, 0);
        tick();
        @(negedge aclk);
        check("rel_s_tready0_high", s0.tready, 1);
        check("rel_s_tready1_high", s1.tready, 1);

        // Five back-to-back words, tlast on the fifth, sink always ready.
        m0.tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            put0(1'b1, mk(vec[i], i == 4));
            @(negedge aclk);
            check("bb_valid", m0.tvalid, i > 0);
            check("bb_occ", occ0, (i > 0) ? 1 : 0);
        end
        tick();
        put0(1'b0, '0);
        @(negedge aclk);
        check("bb_tail_valid", m0.tvalid, 1);
        check("bb_tail_last", m0.tlast, 1);
        tick();
        @(negedge aclk);
        check("bb_done_valid", m0.tvalid, 0);
        check("bb_done_occ", occ0, 0);

        // Fill to 16 with the sink stalled, then a single pop.
        m0.tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            put0(1'b1, mk(32'hA000_0000 + i, 1'b0));
            @(negedge aclk);
            check("fill_ready", s0.tready, 1);
        end
        tick();
        put0(1'b1, mk(32'hA000_0010, 1'b1));
        @(negedge aclk);
        check("full_ready", s0.tready, 0);
        check("full_occ", occ0, 16);
        check("full_valid", m0.tvalid, 1);
        tick();
        m0.tready = 1'b1;
        @(negedge aclk);
        check("pop_full_ready", s0.tready, 0);
        tick();
        m0.tready = 1'b0;
        @(negedge aclk);
        check("reopen_ready", s0.tready, 1);
        check("reopen_occ", occ0, 15);
        tick();
        put0(1'b0, '0);
        @(negedge aclk);
        check("refull_occ", occ0, 16);
        check("refull_ready", s0.tready, 0);
        drain0();

        // Packet mode: no release until a tlast is stored.
        m1.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            put1(1'b1, mk(32'hB000_0000 + i, 1'b0));
            @(negedge aclk);
            check("pm_hold_valid", m1.tvalid, 0);
        end
        tick();
        put1(1'b0, '0);
        @(negedge aclk);
        check("pm_hold_valid", m1.tvalid, 0);
        check("pm_occ3", occ1, 3);
        check("pm_pkt0", pkt1, 0);
        tick();
        put1(1'b1, mk(32'hB000_0003, 1'b1));
        @(negedge aclk);
        check("pm_hold_valid", m1.tvalid, 0);
        tick();
        put1(1'b0, '0);
        @(negedge aclk);
        check("pm_release", m1.tvalid, 1);
        check("pm_pkt1", pkt1, 1);
        check("pm_occ4", occ1, 4);
        for (int k = 1; k <= 4; k++) begin
            tick();
            @(negedge aclk);
            check("pm_pop_pkt", pkt1, (k < 4) ? 1 : 0);
            check("pm_pop_occ", occ1, 4 - k);
        end

        // A tlast pushed on the edge that pops the only stored tlast.
        m1.tready = 1'b0;
        tick();
        put1(1'b1, mk(32'hC000_0000, 1'b1));
        @(negedge aclk);
        tick();
        put1(1'b1, mk(32'hC000_0001, 1'b1));
        m1.tready = 1'b1;
        @(negedge aclk);
        check("same_edge_pre_pkt", pkt1, 1);
        check("same_edge_pre_valid", m1.tvalid, 1);
        tick();
        put1(1'b0, '0);
        m1.tready = 1'b0;
        @(negedge aclk);
        check("same_edge_pkt", pkt1, 1);
        check("same_edge_occ", occ1, 1);
        drain1();

        // Packet mode: 20-word packet longer than the FIFO is released when full.
        m1.tready = 1'b1;
        idx = 0;
        for (int c = 0; c <= 36; c++) begin
            tick();
            if (idx < 20) put1(1'b1, mk(32'hD000_0000 + idx, idx == 19));
            else          put1(1'b0, '0);
            @(negedge aclk);
            check("long_valid", m1.tvalid, (c >= 16) && (c <= 35));
            if (c == 16) begin
                check("long_full_occ", occ1, 16);
                check("long_full_ready", s1.tready, 0);
            end
            if (c == 17) check("long_reopen_ready", s1.tready, 1);
            if (s1.tvalid && s1.tready) idx++;
        end
        check("long_end_occ", occ1, 0);
        m1.tready = 1'b0;

        // Random traffic on both sides at 50%.
        base    = rx0;
        sent    = 0;
        pending = 1'b0;
        for (int c = 0; c < 60000 && (rx0 - base) < 10000; c++) begin
            tick();
            if (!pending) begin
                if (sent < 10000 && $urandom_range(0, 1) == 1) begin
                    put0(1'b1, rand_word());
                    pending = 1'b1;
                end else begin
                    put0(1'b0, '0);
                end
            end
            m0.tready = ($urandom_range(0, 1) == 1);
            @(negedge aclk);
            if (pending && s0.tready) begin
                pending = 1'b0;
                sent++;
            end
        end
        check("rand_words", rx0 - base, 10000);
        tick();
        put0(1'b0, '0);
        drain0();

        // Reset with seven words stored.
        for (int i = 0; i < 7; i++) begin
            tick();
            put0(1'b1, mk(32'hE000_0000 + i, i == 6));
            @(negedge aclk);
        end
        tick();
        put0(1'b0, '0);
        @(negedge aclk);
        check("pre_rst_occ", occ0, 7);
        tick();
        aresetn = 1'b0;
        want0.delete();
        want1.delete();
        #1;
        check("mid_rst_occ", occ0, 0);
        check("mid_rst_valid", m0.tvalid, 0);
        check("mid_rst_ready", s0.tready, 0);
        check("mid_rst_pkt", pkt0, 0);
        tick();
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst_ready_low", s0.tready, 0);
        tick();
        @(negedge aclk);
        check("post_rst_ready_high", s0.tready, 1);
        check("post_rst_occ", occ0, 0);
        m0.tready = 1'b1;
        repeat (3) tick();
        @(negedge aclk);
        check("post_rst_no_stale", m0.tvalid, 0);

        check("sb0_empty", want0.size(), 0);
        check("sb1_empty", want1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
